// File: rtl/tuner_phy_pkg.sv
// Shared state and error encodings for the multi-channel tuner search/lock sequencer.
package tuner_phy_pkg;

   typedef enum logic [3:0] {
      IDLE,
      SEARCH_TRIG,
      SEARCH_WAIT,
      ALLOC,
      LOCK_TRIG,
      MONITOR,
      INTR_ACK,
      RESUME,
      ERR
   } tuner_seq_state_e;

   typedef enum logic [1:0] {
      ERR_NONE,
      ERR_NO_PEAK,
      ERR_TIMEOUT,
      ERR_RELOCK_LIMIT
   } tuner_seq_err_e;

endpackage

// File: rtl/tuner_multi_ch_seq_peak_alloc.sv
// Sequential peak scanner: walks one peak per cycle and picks the first one that
// clears the previous channel's code by at least ALLOC_GUARD.
module tuner_peak_alloc #(
   parameter int unsigned DAC_WIDTH   = 8,
   parameter int unsigned ADC_WIDTH   = 8,
   parameter int unsigned NUM_TARGET  = 8,
   parameter int unsigned ALLOC_GUARD = 4,
   localparam int unsigned CNT_W = $clog2(NUM_TARGET) + 1
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 start,
   input  logic [NUM_TARGET-1:0][DAC_WIDTH-1:0] codes,
   input  logic [NUM_TARGET-1:0][ADC_WIDTH-1:0] pwrs,
   input  logic [CNT_W-1:0]                     cnt,
   input  logic [DAC_WIDTH-1:0]                 prev_code,
   input  logic                                 prev_valid,
   output logic                                 done,
   output logic                                 found,
   output logic [DAC_WIDTH-1:0]                 code,
   output logic [ADC_WIDTH-1:0]                 pwr
);

   localparam int unsigned IDX_W = (NUM_TARGET > 1) ? $clog2(NUM_TARGET) : 1;

   logic             active;
   logic [CNT_W-1:0] idx;
   logic [IDX_W-1:0] sel;
   logic             in_range;
   logic             match;
   logic [DAC_WIDTH:0] floor_code;

   always_comb begin
      sel        = idx[IDX_W-1:0];
      in_range   = (idx < cnt) && (idx < CNT_W'(NUM_TARGET));
      // one extra bit so prev_code + guard never wraps back into range
      floor_code = {1'b0, prev_code} + (DAC_WIDTH+1)'(ALLOC_GUARD);
      match      = in_range && (!prev_valid || ({1'b0, codes[sel]} >= floor_code));
      done       = active && (match || !in_range);
      found      = active && match;
      code       = codes[sel];
      pwr        = pwrs[sel];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         active <= 1'b0;
         idx    <= '0;
      end else if (start) begin
         active <= 1'b1;
         idx    <= '0;
      end else if (active) begin
         if (done) active <= 1'b0;
         else      idx    <= idx + CNT_W'(1);
      end
   end

endmodule

// File: rtl/tuner_multi_ch_seq.sv
// Multi-channel search/lock sequencer: searches each ring in order, allocates
// monotonic guarded peaks, triggers lock, then services lock interrupts.
module tuner_multi_ch_seq
   import tuner_phy_pkg::*;
#(
   parameter int unsigned NUM_CH         = 4,
   parameter int unsigned DAC_WIDTH      = 8,
   parameter int unsigned ADC_WIDTH      = 8,
   parameter int unsigned NUM_TARGET     = 8,
   parameter int unsigned ALLOC_GUARD    = 4,
   parameter int unsigned SEARCH_TIMEOUT = 4096,
   parameter int unsigned MAX_RELOCK     = 3,
   localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int unsigned RL_W  = $clog2(MAX_RELOCK + 1),
   localparam int unsigned CNT_W = $clog2(NUM_TARGET) + 1
) (
   input  logic                                             i_clk,
   input  logic                                             i_rst,
   input  logic                                             i_start,
   output logic                                             o_busy,
   output logic                                             o_done,
   output logic                                             o_err,
   output tuner_seq_err_e                                   o_err_code,
   output logic [CH_W-1:0]                                  o_err_ch,
   output logic [NUM_CH-1:0]                                o_search_trig_val,
   input  logic [NUM_CH-1:0]                                i_search_trig_rdy,
   input  logic [NUM_CH-1:0]                                i_search_peaks_val,
   output logic [NUM_CH-1:0]                                o_search_peaks_rdy,
   input  logic [NUM_CH-1:0][NUM_TARGET-1:0][DAC_WIDTH-1:0] i_peak_tune_codes,
   input  logic [NUM_CH-1:0][NUM_TARGET-1:0][ADC_WIDTH-1:0] i_peak_pwr_codes,
   input  logic [NUM_CH-1:0][CNT_W-1:0]                     i_peaks_cnt,
   output logic [NUM_CH-1:0]                                o_lock_trig_val,
   input  logic [NUM_CH-1:0]                                i_lock_trig_rdy,
   input  logic [NUM_CH-1:0]                                i_lock_intr_val,
   output logic [NUM_CH-1:0]                                o_lock_intr_rdy,
   output logic [NUM_CH-1:0]                                o_lock_resume_val,
   input  logic [NUM_CH-1:0]                                i_lock_resume_rdy,
   output logic [NUM_CH-1:0][DAC_WIDTH-1:0]                 o_cfg_ring_tune_peak,
   output logic [NUM_CH-1:0][ADC_WIDTH-1:0]                 o_cfg_pwr_peak,
   output logic [NUM_CH-1:0]                                o_ch_locked,
   output logic [NUM_CH-1:0][RL_W-1:0]                      o_relock_cnt
);

   localparam int unsigned TO_W = (SEARCH_TIMEOUT > 1) ? $clog2(SEARCH_TIMEOUT) : 1;

   tuner_seq_state_e state, state_nx;

   logic [CH_W-1:0]                     ch;
   logic [CH_W-1:0]                     k;
   logic [CH_W-1:0]                     pick;
   logic                                pick_valid;
   logic [DAC_WIDTH-1:0]                prev_code;
   logic                                prev_valid;
   logic [TO_W-1:0]                     to_cnt;
   logic                                trig_armed;
   logic [NUM_TARGET-1:0][DAC_WIDTH-1:0] lat_codes;
   logic [NUM_TARGET-1:0][ADC_WIDTH-1:0] lat_pwrs;
   logic [CNT_W-1:0]                    lat_cnt;
   tuner_seq_err_e                      err_code;
   logic                                alloc_start;
   logic                                alloc_done;
   logic                                alloc_found;
   logic [DAC_WIDTH-1:0]                alloc_code;
   logic [ADC_WIDTH-1:0]                alloc_pwr;

   assign o_busy      = !(state == IDLE || state == MONITOR || state == ERR);
   assign o_err       = (state == ERR);
   assign o_err_code  = err_code;
   assign alloc_start = (state == SEARCH_WAIT) && i_search_peaks_val[ch];

   tuner_peak_alloc #(
      .DAC_WIDTH   (DAC_WIDTH),
      .ADC_WIDTH   (ADC_WIDTH),
      .NUM_TARGET  (NUM_TARGET),
      .ALLOC_GUARD (ALLOC_GUARD)
   ) u_alloc (
      .clk        (i_clk),
      .rst        (i_rst),
      .start      (alloc_start),
      .codes      (lat_codes),
      .pwrs       (lat_pwrs),
      .cnt        (lat_cnt),
      .prev_code  (prev_code),
      .prev_valid (prev_valid),
      .done       (alloc_done),
      .found      (alloc_found),
      .code       (alloc_code),
      .pwr        (alloc_pwr)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx           = state;
      o_search_trig_val  = '0;
      o_search_peaks_rdy = '0;
      o_lock_trig_val    = '0;
      o_lock_intr_rdy    = '0;
      o_lock_resume_val  = '0;
      pick_valid         = 1'b0;
      pick               = '0;
      for (int unsigned i = NUM_CH; i > 0; i--) begin
         if (i_lock_intr_val[i-1]) begin
            pick_valid = 1'b1;
            pick       = CH_W'(i - 1);
         end
      end
      case (state)
         IDLE, ERR: if (i_start) state_nx = SEARCH_TRIG;
         SEARCH_TRIG: begin
            o_search_trig_val[ch] = 1'b1;
            if (i_search_trig_rdy[ch]) state_nx = SEARCH_WAIT;
         end
         SEARCH_WAIT: begin
            o_search_peaks_rdy[ch] = 1'b1;
            if (i_search_peaks_val[ch])                     state_nx = ALLOC;
            else if (to_cnt == TO_W'(SEARCH_TIMEOUT - 1))   state_nx = ERR;
         end
         ALLOC: if (alloc_done) state_nx = alloc_found ? LOCK_TRIG : ERR;
         LOCK_TRIG: begin
            // first cycle only lets the freshly written cfg settle
            o_lock_trig_val[ch] = trig_armed;
            if (trig_armed && i_lock_trig_rdy[ch])
               state_nx = (ch == CH_W'(NUM_CH - 1)) ? MONITOR : SEARCH_TRIG;
         end
         MONITOR: if (pick_valid) state_nx = INTR_ACK;
         INTR_ACK: begin
            o_lock_intr_rdy[k] = 1'b1;
            if (i_lock_intr_val[k])
               state_nx = (o_relock_cnt[k] == RL_W'(MAX_RELOCK)) ? ERR : RESUME;
         end
         RESUME: begin
            o_lock_resume_val[k] = 1'b1;
            if (i_lock_resume_rdy[k]) state_nx = MONITOR;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ch                   <= '0;
         k                    <= '0;
         prev_code            <= '0;
         prev_valid           <= 1'b0;
         to_cnt               <= '0;
         trig_armed           <= 1'b0;
         lat_codes            <= '0;
         lat_pwrs             <= '0;
         lat_cnt              <= '0;
         err_code             <= ERR_NONE;
         o_err_ch             <= '0;
         o_done               <= 1'b0;
         o_cfg_ring_tune_peak <= '0;
         o_cfg_pwr_peak       <= '0;
         o_ch_locked          <= '0;
         o_relock_cnt         <= '0;
      end else begin
         o_done <= 1'b0;
         case (state)
            IDLE, ERR: begin
               if (i_start) begin
                  ch           <= '0;
                  prev_valid   <= 1'b0;
                  o_ch_locked  <= '0;
                  o_relock_cnt <= '0;
                  err_code     <= ERR_NONE;
                  o_err_ch     <= '0;
               end
            end
            SEARCH_TRIG: to_cnt <= '0;
            SEARCH_WAIT: begin
               if (i_search_peaks_val[ch]) begin
                  lat_codes <= i_peak_tune_codes[ch];
                  lat_pwrs  <= i_peak_pwr_codes[ch];
                  lat_cnt   <= i_peaks_cnt[ch];
               end else if (to_cnt == TO_W'(SEARCH_TIMEOUT - 1)) begin
                  err_code <= ERR_TIMEOUT;
                  o_err_ch <= ch;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
            end
            ALLOC: begin
               if (alloc_done && alloc_found) begin
                  o_cfg_ring_tune_peak[ch] <= alloc_code;
                  o_cfg_pwr_peak[ch]       <= alloc_pwr;
                  prev_code                <= alloc_code;
                  prev_valid               <= 1'b1;
                  trig_armed               <= 1'b0;
               end else if (alloc_done) begin
                  err_code <= ERR_NO_PEAK;
                  o_err_ch <= ch;
               end
            end
            LOCK_TRIG: begin
               if (!trig_armed) begin
                  trig_armed <= 1'b1;
               end else if (i_lock_trig_rdy[ch]) begin
                  o_ch_locked[ch] <= 1'b1;
                  trig_armed      <= 1'b0;
                  if (ch == CH_W'(NUM_CH - 1)) o_done <= 1'b1;
                  else                         ch     <= ch + CH_W'(1);
               end
            end
            MONITOR: if (pick_valid) k <= pick;
            INTR_ACK: begin
               if (i_lock_intr_val[k]) begin
                  o_ch_locked[k] <= 1'b0;
                  // the over-limit count is not representable in RL_W bits, so it saturates
                  if (o_relock_cnt[k] == RL_W'(MAX_RELOCK)) begin
                     err_code <= ERR_RELOCK_LIMIT;
                     o_err_ch <= k;
                  end else begin
                     o_relock_cnt[k] <= o_relock_cnt[k] + RL_W'(1);
                  end
               end
            end
            RESUME: if (i_lock_resume_rdy[k]) o_ch_locked[k] <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule
